mul_accumulator: RTL and testbench
==================================

// Module: mul_accumulator
// PURPOSE
//  Downstream consumer of the signed ALU multiplier. Accumulates successive N-bit products
//  (add/sub/load) into a saturating signed accumulator with sticky overflow tracking.
//  Delivers the final sum through a valid/ready result port when a FLUSH op arrives.
//  Sits in the EX stage between the multiplier output and the writeback mux.
// PARAMETERS
//  N      24  data width; matches the multiplier width
//  CNT_W  8   width of the accepted-op counter
//  SAT    1   1: clamp to signed limits on overflow; 0: wrap (flag still set)
// PORTS
//  clk        in   1      single clock; all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      product/op beat valid
//  in_ready   out  1      block can accept a beat
//  in_op      in   2      mac_op_t: ACC=00, LOAD=01, SUB=10, FLUSH=11
//  in_prod    in   N      signed product from the multiplier
//  in_movf    in   1      multiplier overflow flag for this product
//  acc_o      out  N      live accumulator value (registered)
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts result
//  out_res    out  N      flushed accumulator value
//  out_cnt    out  CNT_W  ops accumulated since last flush (saturating)
//  out_sat    out  1      saturation/wrap occurred in this batch
//  out_movf   out  1      any in_movf seen in this batch
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=RUN, acc=0, cnt=0, sticky flags=0, out_valid=0,
//    out_res/out_cnt/out_sat/out_movf=0. A reset in HOLD drops the pending result.
//  - FSM, two states. RUN: in_ready=1. HOLD: in_ready=0, out_valid=1.
//  - Accept = in_valid & in_ready. acc_o updates the cycle after accept (1-cycle latency).
//  - ACC: acc += prod. SUB: acc -= prod. LOAD: acc = prod; stickies cleared, then
//    set by this beat. Each of ACC/SUB/LOAD increments cnt (LOAD sets cnt=1).
//    cnt saturates at 2^CNT_W-1.
//  - Arithmetic: sign-extend both operands to N+1 bits. Overflow when bits [N] and [N-1]
//    of the sum differ. On overflow with SAT=1, clamp: +overflow -> 2^(N-1)-1,
//    -overflow -> -2^(N-1). With SAT=0, keep the low N bits. Either way set sat_sticky.
//  - in_movf=1 on an accepted ACC/SUB/LOAD sets movf_sticky. The product is used as
//    given (already wrapped).
//  - FLUSH in RUN: out_res<=acc, out_cnt<=cnt, out_sat<=sat_sticky, out_movf<=movf_sticky.
//    Then acc, cnt and stickies are cleared and state goes to HOLD. in_prod and in_movf
//    are ignored for FLUSH.
//  - HOLD: outputs stay stable while out_ready=0. When out_valid & out_ready, go to RUN
//    next cycle and drop out_valid. in_ready rises the same edge. No bypass.
//  - FLUSH on an empty batch (cnt=0) is legal and returns res=0, cnt=0.
//  - out_valid never depends combinationally on out_ready. in_ready is a pure function
//    of the state register.
// STRUCTURE
//  - alu_pkg: mac_op_t enum, macc_state_t {RUN,HOLD}, localparams for signed MAX/MIN per N.
//  - Sub-module sat_addsub #(N,SAT): combinational (a, b, sub) -> (y, ovf),
//    covering N+1 extension and clamp.
//  - Top: FSM, accumulator/counter/sticky registers, result holding registers.
// TESTING (N=24, SAT=1, CNT_W=8)
//  1. LOAD 100, ACC 250, SUB 50, FLUSH -> out_res=300, out_cnt=3, sat=0, movf=0;
//     acc_o=0 next cycle.
//  2. LOAD 0x7FFFF0, ACC 0x20, FLUSH -> acc_o=0x7FFFFF after ACC; out_res=0x7FFFFF, out_sat=1.
//  3. LOAD 0x800005, SUB 0x10 -> acc_o=0x800000. SAT=0 build: acc_o=0x7FFFF5, sat=1.
//  4. FLUSH, out_ready=0 for 5 cycles -> out_valid=1, out_res stable, in_ready=0;
//     out_ready=1 -> one handshake, in_ready=1 next cycle.
//  5. ACC 7 with in_movf=1, ACC 1, FLUSH -> out_res=8, out_movf=1; next batch reports movf=0.
//  6. 300 ACC 1 then FLUSH -> out_cnt=255. Async rst_n pulse in HOLD -> out_valid=0,
//     in_ready=1 immediately, acc_o=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and limits for the EX-stage multiply-accumulate block.
// Op encoding matches what the multiplier issue logic drives.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ACC   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_SUB   = 2'b10,
    OP_FLUSH = 2'b11
  } mac_op_t;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } macc_state_t;

  localparam int MAC_N     = 24;
  localparam int MAC_CNT_W = 8;

  localparam logic [MAC_N-1:0] MAC_MAX = {1'b0, {(MAC_N-1){1'b1}}};
  localparam logic [MAC_N-1:0] MAC_MIN = {1'b1, {(MAC_N-1){1'b0}}};

endpackage

// File: rtl/mul_accumulator_if.sv
// Product-in / result-out handshake bundle for mul_accumulator.
// master = upstream multiplier plus writeback consumer, slave = the accumulator.
interface mul_accumulator_if
  import alu_pkg::*;
#(
  parameter int N     = 24,
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  mac_op_t          in_op;
  logic [N-1:0]     in_prod;
  logic             in_movf;
  logic [N-1:0]     acc_o;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_res;
  logic [CNT_W-1:0] out_cnt;
  logic             out_sat;
  logic             out_movf;

  modport master (
    output in_valid, in_op, in_prod, in_movf, out_ready,
    input  in_ready, acc_o, out_valid, out_res, out_cnt, out_sat, out_movf
  );

  modport slave (
    input  in_valid, in_op, in_prod, in_movf, out_ready,
    output in_ready, acc_o, out_valid, out_res, out_cnt, out_sat, out_movf
  );

endinterface

// File: rtl/mul_accumulator_sat_addsub.sv
// Combinational signed add/subtract with one guard bit.
// Overflow is flagged whenever the guard and sign bits disagree; SAT selects clamp or wrap.
module sat_addsub #(
  parameter int N   = 24,
  parameter int SAT = 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] y,
  output logic         ovf
);

  localparam logic [N-1:0] POS_LIMIT = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] NEG_LIMIT = {1'b1, {(N-1){1'b0}}};

  logic [N:0] a_ext;
  logic [N:0] b_ext;
  logic [N:0] sum;

  always_comb begin
    a_ext = {a[N-1], a};
    b_ext = {b[N-1], b};
    sum   = sub ? (a_ext - b_ext) : (a_ext + b_ext);
    ovf   = sum[N] ^ sum[N-1];
    y     = sum[N-1:0];
    // The guard bit carries the true sign, so it picks the clamp direction.
    if (ovf && (SAT != 0)) begin
      y = sum[N] ? NEG_LIMIT : POS_LIMIT;
    end
  end

endmodule

// File: rtl/mul_accumulator.sv
// Saturating signed accumulator for multiplier products with sticky flags.
// A FLUSH op snapshots the batch into result registers and holds until downstream takes it.
module mul_accumulator
  import alu_pkg::*;
#(
  parameter int N     = 24,
  parameter int CNT_W = 8,
  parameter int SAT   = 1
) (
  input logic               clk,
  input logic               rst_n,
  mul_accumulator_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  macc_state_t      state;
  logic [N-1:0]     acc;
  logic [CNT_W-1:0] cnt;
  logic             sat_sticky;
  logic             movf_sticky;

  logic [N-1:0]     res_q;
  logic [CNT_W-1:0] res_cnt_q;
  logic             res_sat_q;
  logic             res_movf_q;

  logic             accept;
  logic [N-1:0]     add_a;
  logic             add_sub;
  logic [N-1:0]     add_y;
  logic             add_ovf;

  assign bus.in_ready  = (state == RUN);
  assign bus.out_valid = (state == HOLD);
  assign bus.acc_o     = acc;
  assign bus.out_res   = res_q;
  assign bus.out_cnt   = res_cnt_q;
  assign bus.out_sat   = res_sat_q;
  assign bus.out_movf  = res_movf_q;

  assign accept = bus.in_valid && (state == RUN);

  // LOAD reuses the adder as 0 + prod, which can never overflow.
  always_comb begin
    add_a   = (bus.in_op == OP_LOAD) ? '0 : acc;
    add_sub = (bus.in_op == OP_SUB);
  end

  sat_addsub #(
    .N   (N),
    .SAT (SAT)
  ) u_addsub (
    .a   (add_a),
    .b   (bus.in_prod),
    .sub (add_sub),
    .y   (add_y),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      acc         <= '0;
      cnt         <= '0;
      sat_sticky  <= 1'b0;
      movf_sticky <= 1'b0;
      res_q       <= '0;
      res_cnt_q   <= '0;
      res_sat_q   <= 1'b0;
      res_movf_q  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (accept) begin
            case (bus.in_op)
              OP_LOAD: begin
                acc         <= add_y;
                cnt         <= CNT_ONE;
                sat_sticky  <= add_ovf;
                movf_sticky <= bus.in_movf;
              end
              OP_ACC, OP_SUB: begin
                acc         <= add_y;
                if (cnt != CNT_MAX) begin
                  cnt <= cnt + CNT_ONE;
                end
                sat_sticky  <= sat_sticky | add_ovf;
                movf_sticky <= movf_sticky | bus.in_movf;
              end
              OP_FLUSH: begin
                res_q       <= acc;
                res_cnt_q   <= cnt;
                res_sat_q   <= sat_sticky;
                res_movf_q  <= movf_sticky;
                acc         <= '0;
                cnt         <= '0;
                sat_sticky  <= 1'b0;
                movf_sticky <= 1'b0;
                state       <= HOLD;
              end
              default: begin
                acc <= acc;
              end
            endcase
          end
        end
        HOLD: begin
          // Result registers stay frozen until the handshake completes.
          if (bus.out_ready) begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_accumulator.sv
// Directed bench for mul_accumulator: an arithmetic model checked every cycle,
// plus hand-computed literals for each scenario.
module tb_mul_accumulator;
  import alu_pkg::*;

  localparam int N     = 24;
  localparam int CNT_W = 8;
  localparam longint MAXV = 64'sd8388607;
  localparam longint MINV = -64'sd8388608;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   check_en;

  mul_accumulator_if #(.N(N), .CNT_W(CNT_W)) bus ();

  mul_accumulator #(.N(N), .CNT_W(CNT_W), .SAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: plain integers, clamped to the signed 24-bit range.
  longint m_acc   = 0;
  int     m_cnt   = 0;
  bit     m_sat   = 0;
  bit     m_movf  = 0;
  bit     m_hold  = 0;
  longint m_res   = 0;
  int     m_rcnt  = 0;
  bit     m_rsat  = 0;
  bit     m_rmovf = 0;

  function automatic longint raw_next(mac_op_t op, longint acc, logic [N-1:0] prod);
    longint p;
    p = longint'($signed(prod));
    if (op == OP_LOAD) return p;
    if (op == OP_SUB) return acc - p;
    return acc + p;
  endfunction

  function automatic bit out_of_range(longint v);
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic longint clamp(longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc <= 0; m_cnt <= 0; m_sat <= 0; m_movf <= 0; m_hold <= 0;
      m_res <= 0; m_rcnt <= 0; m_rsat <= 0; m_rmovf <= 0;
    end else if (m_hold) begin
      if (bus.out_ready) m_hold <= 0;
    end else if (bus.in_valid) begin
      if (bus.in_op == OP_FLUSH) begin
        m_res <= m_acc; m_rcnt <= m_cnt; m_rsat <= m_sat; m_rmovf <= m_movf;
        m_acc <= 0; m_cnt <= 0; m_sat <= 0; m_movf <= 0; m_hold <= 1;
      end else begin
        m_acc  <= clamp(raw_next(bus.in_op, m_acc, bus.in_prod));
        m_sat  <= ((bus.in_op == OP_LOAD) ? 1'b0 : m_sat)
                  | out_of_range(raw_next(bus.in_op, m_acc, bus.in_prod));
        m_movf <= ((bus.in_op == OP_LOAD) ? 1'b0 : m_movf) | bus.in_movf;
        m_cnt  <= (bus.in_op == OP_LOAD) ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      end
    end
  end

  task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (rst_n && check_en) begin
      check_output("in_ready",  32'(bus.in_ready),  32'(!m_hold));
      check_output("out_valid", 32'(bus.out_valid), 32'(m_hold));
      check_output("acc_o",     32'(bus.acc_o),     32'(m_acc[N-1:0]));
      check_output("out_res",   32'(bus.out_res),   32'(m_res[N-1:0]));
      check_output("out_cnt",   32'(bus.out_cnt),   32'(m_rcnt[CNT_W-1:0]));
      check_output("out_sat",   32'(bus.out_sat),   32'(m_rsat));
      check_output("out_movf",  32'(bus.out_movf),  32'(m_rmovf));
    end
  end

  // Presents one beat starting just after a falling edge; returns on the next falling edge.
  task automatic apply_stimulus(mac_op_t op, logic [N-1:0] prod, logic movf);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_prod  = prod;
    bus.in_movf  = movf;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_movf  = 1'b0;
  endtask

  task automatic wait_result_taken();
    int n;
    n = 0;
    while (bus.out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_output("handshake_timeout", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic flush_and_check(string tag, logic [N-1:0] res, int cnt, logic sat, logic movf);
    apply_stimulus(OP_FLUSH, 24'h000000, 1'b0);
    check_output({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_output({tag, "_res"},   32'(bus.out_res),   32'(res));
    check_output({tag, "_cnt"},   32'(bus.out_cnt),   32'(cnt));
    check_output({tag, "_sat"},   32'(bus.out_sat),   32'(sat));
    check_output({tag, "_movf"},  32'(bus.out_movf),  32'(movf));
    if (bus.out_ready) wait_result_taken();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    check_en      = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_ACC;
    bus.in_prod   = '0;
    bus.in_movf   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_output("rst_acc",       32'(bus.acc_o),     32'd0);
    check_output("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_out_res",   32'(bus.out_res),   32'd0);
    rst_n    = 1'b1;
    check_en = 1'b1;
    @(negedge clk);

    $display("[TB] scenario 1: load/acc/sub");
    apply_stimulus(OP_LOAD, 24'd100, 1'b0);
    check_output("s1_load_acc", 32'(bus.acc_o), 32'd100);
    apply_stimulus(OP_ACC, 24'd250, 1'b0);
    apply_stimulus(OP_SUB, 24'd50, 1'b0);
    check_output("s1_sum_acc", 32'(bus.acc_o), 32'd300);
    flush_and_check("s1", 24'd300, 3, 1'b0, 1'b0);
    check_output("s1_acc_cleared", 32'(bus.acc_o), 32'd0);

    $display("[TB] scenario 2: positive clamp");
    apply_stimulus(OP_LOAD, 24'h7FFFF0, 1'b0);
    apply_stimulus(OP_ACC, 24'h000020, 1'b0);
    check_output("s2_clamp_acc", 32'(bus.acc_o), 32'h7FFFFF);
    flush_and_check("s2", 24'h7FFFFF, 2, 1'b1, 1'b0);

    $display("[TB] scenario 3: negative clamp");
    apply_stimulus(OP_LOAD, 24'h800005, 1'b0);
    apply_stimulus(OP_SUB, 24'h000010, 1'b0);
    check_output("s3_clamp_acc", 32'(bus.acc_o), 32'h800000);
    flush_and_check("s3", 24'h800000, 2, 1'b1, 1'b0);

    $display("[TB] scenario 4: backpressure");
    apply_stimulus(OP_LOAD, 24'd42, 1'b0);
    bus.out_ready = 1'b0;
    flush_and_check("s4", 24'd42, 1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(OP_ACC, 24'd9, 1'b0);
      check_output("s4_hold_valid", 32'(bus.out_valid), 32'd1);
      check_output("s4_hold_res",   32'(bus.out_res),   32'd42);
      check_output("s4_hold_ready", 32'(bus.in_ready),  32'd0);
      check_output("s4_hold_acc",   32'(bus.acc_o),     32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_output("s4_release_valid", 32'(bus.out_valid), 32'd0);
    check_output("s4_release_ready", 32'(bus.in_ready),  32'd1);

    $display("[TB] scenario 5: multiplier overflow sticky");
    apply_stimulus(OP_ACC, 24'd7, 1'b1);
    apply_stimulus(OP_ACC, 24'd1, 1'b0);
    flush_and_check("s5a", 24'd8, 2, 1'b0, 1'b1);
    apply_stimulus(OP_ACC, 24'hFFFFFD, 1'b0);
    flush_and_check("s5b", 24'hFFFFFD, 1, 1'b0, 1'b0);

    $display("[TB] scenario 6: empty flush, counter saturation, reset in hold");
    flush_and_check("s6_empty", 24'd0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(OP_ACC, 24'd1, 1'b0);
    end
    bus.out_ready = 1'b0;
    flush_and_check("s6", 24'd300, 255, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("s6_rst_valid", 32'(bus.out_valid), 32'd0);
    check_output("s6_rst_ready", 32'(bus.in_ready),  32'd1);
    check_output("s6_rst_acc",   32'(bus.acc_o),     32'd0);
    check_output("s6_rst_res",   32'(bus.out_res),   32'd0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    apply_stimulus(OP_ACC, 24'd5, 1'b0);
    check_output("s6_after_rst_acc", 32'(bus.acc_o), 32'd5);
    flush_and_check("s6_post", 24'd5, 1, 1'b0, 1'b0);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
